// File: rtl/pin_io_pkg.sv
// Shared defaults and helpers for the pad front-end.
// Consumed by pin_frontend and pin_filter.
package pin_io_pkg;

    localparam int unsigned PIN_WIDTH_DEF  = 32;
    localparam int unsigned PIN_SYNC_DEF   = 2;
    localparam int unsigned PIN_FILTER_DEF = 4;

    // Counter must hold values 0..len, so len+1 distinct states.
    function automatic int unsigned filt_cnt_w(input int unsigned len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/pin_filter.sv
// One pin's glitch filter: filt follows sync only after FILTER_LEN stable cycles.
// Built only when PIN_FILTER_EN is defined; otherwise filt is a plain register of sync.
module pin_filter
    import pin_io_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PIN_FILTER_DEF,
    parameter logic        INIT       = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic filt_o
);

    logic filt_q, filt_d;

`ifdef PIN_FILTER_EN
    localparam int unsigned       CntW   = filt_cnt_w(FILTER_LEN);
    localparam logic [CntW-1:0]   CntMax = CntW'(FILTER_LEN - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_i == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            filt_d = sync_i;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam int unsigned unused_filter_len = FILTER_LEN;

    always_comb begin
        filt_d = sync_i;
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= INIT;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/pin_frontend.sv
// Pad front-end for the p1v core: synchroniser, optional glitch filter (PIN_FILTER_EN),
// core input mux, rise/fall event pulses and registered pad drive/enable.
module pin_frontend
    import pin_io_pkg::*;
#(
    parameter int unsigned      WIDTH       = PIN_WIDTH_DEF,
    parameter int unsigned      SYNC_STAGES = PIN_SYNC_DEF,
    parameter int unsigned      FILTER_LEN  = PIN_FILTER_DEF,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic             pllX16,
    input  logic             res,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oe,
    input  logic [WIDTH-1:0] pin_out,
    input  logic [WIDTH-1:0] pin_dir,
    output logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic [WIDTH-1:0] pad_o_q, pad_oe_q;

    always_ff @(posedge pllX16 or posedge res) begin
        if (res) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= INIT;
            end
        end else begin
            sync_q[0] <= pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_filter
        pin_filter #(
            .FILTER_LEN (FILTER_LEN),
            .INIT       (INIT[i])
        ) u_pin_filter (
            .clk_i  (pllX16),
            .rst_i  (res),
            .sync_i (sync_q[SYNC_STAGES-1][i]),
            .filt_o (filt[i])
        );
    end

    // Output-mode pins suppress edges; the filter keeps tracking so no catch-up edge appears.
    always_ff @(posedge pllX16 or posedge res) begin
        if (res) begin
            prev_q   <= INIT;
            rise_q   <= '0;
            fall_q   <= '0;
            pad_o_q  <= '0;
            pad_oe_q <= '0;
        end else begin
            prev_q   <= filt;
            rise_q   <= filt & ~prev_q & ~pin_dir;
            fall_q   <= ~filt & prev_q & ~pin_dir;
            pad_o_q  <= pin_out;
            pad_oe_q <= pin_dir;
        end
    end

    assign pin_in = (pin_dir & pin_out) | (~pin_dir & filt);
    assign rise   = rise_q;
    assign fall   = fall_q;
    assign pad_o  = pad_o_q;
    assign pad_oe = pad_oe_q;

endmodule
